// File: rtl/seg7_pkg.sv
// rtl/seg7_pkg.sv - glyph table shared with the segment encoder, plus scan FSM states
package seg7_pkg;

  // Active-low a..g, seg[6]=a; index is the hex value the glyph represents.
  localparam logic [6:0] glyph_tbl [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  localparam logic [6:0] seg_blank = 7'b1111111;

  typedef enum logic {
    st_track = 1'b0,
    st_held  = 1'b1
  } scan_state_e;

endpackage

// File: rtl/seg7_glyph_decode.sv
// rtl/seg7_glyph_decode.sv - combinational segment pattern to hex nibble mapper
module seg7_glyph_decode
  import seg7_pkg::*;
(
  input  logic [6:0] seg,
  output logic [3:0] nibble,
  output logic       illegal
);

  // Unknown patterns (blank included) read as 0 so the frame stays well defined.
  always_comb begin
    nibble  = 4'h0;
    illegal = 1'b1;
    for (int i = 0; i < 16; i++) begin
      if (seg == glyph_tbl[i]) begin
        nibble  = 4'(i);
        illegal = 1'b0;
      end
    end
  end

endmodule

// File: rtl/seg7_scan_decoder.sv
// rtl/seg7_scan_decoder.sv - recovers a hex frame from a multiplexed 7-segment display scan
module seg7_scan_decoder
  import seg7_pkg::*;
#(
  parameter int NUM_DIGITS    = 4,
  parameter int STABLE_CYCLES = 4
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [6:0]              seg,
  input  logic [NUM_DIGITS-1:0]   an,
  output logic [4*NUM_DIGITS-1:0] value,
  output logic [NUM_DIGITS-1:0]   digit_err,
  output logic                    frame_valid,
  output logic [7:0]              glitch_cnt
);

  localparam logic [7:0] stable_n = 8'(STABLE_CYCLES);

  logic [6:0]              seg_q, seg_p;
  logic [NUM_DIGITS-1:0]   an_q, an_p;
  logic [NUM_DIGITS-1:0]   sel;
  logic                    valid_sel, same, accept;
  logic [7:0]              cnt_q, cnt_d;
  scan_state_e             state_q, state_d;
  logic [NUM_DIGITS-1:0]   mask_q;
  logic [4*NUM_DIGITS-1:0] slot_val;
  logic [NUM_DIGITS-1:0]   slot_err;
  logic [3:0]              nib;
  logic                    illegal;

  seg7_glyph_decode u_decode (
    .seg     (seg_q),
    .nibble  (nib),
    .illegal (illegal)
  );

  assign sel       = ~an_q;
  assign valid_sel = (sel != '0) && ((sel & (sel - NUM_DIGITS'(1))) == '0);
  assign same      = (seg_q == seg_p) && (an_q == an_p);

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    accept  = 1'b0;
    if (!valid_sel) begin
      state_d = st_track;
      cnt_d   = 8'd0;
    end else if (state_q == st_held) begin
      if (!same) begin
        state_d = st_track;
        cnt_d   = 8'd1;
      end
    end else if (same) begin
      cnt_d = cnt_q + 8'd1;
      if (cnt_d == stable_n) begin
        accept  = 1'b1;
        state_d = st_held;
      end
    end else begin
      cnt_d = 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q <= st_track;
      cnt_q   <= 8'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // The previous-sample copy lets the FSM compare consecutive register contents.
  always_ff @(posedge clk) begin
    if (!rst) begin
      seg_q       <= seg_blank;
      an_q        <= '1;
      seg_p       <= seg_blank;
      an_p        <= '1;
      glitch_cnt  <= 8'd0;
      slot_val    <= '0;
      slot_err    <= '0;
      mask_q      <= '0;
      value       <= '0;
      digit_err   <= '0;
      frame_valid <= 1'b0;
    end else begin
      seg_q <= seg;
      an_q  <= an;
      seg_p <= seg_q;
      an_p  <= an_q;

      if (!valid_sel && glitch_cnt != 8'hff)
        glitch_cnt <= glitch_cnt + 8'd1;

      for (int i = 0; i < NUM_DIGITS; i++) begin
        if (accept && sel[i]) begin
          slot_val[4*i +: 4] <= nib;
          slot_err[i]        <= illegal;
        end
      end

      // A full mask publishes the slots as they stood, then restarts collection.
      frame_valid <= 1'b0;
      if (&mask_q) begin
        value       <= slot_val;
        digit_err   <= slot_err;
        frame_valid <= 1'b1;
        mask_q      <= accept ? sel : '0;
      end else if (accept) begin
        mask_q <= mask_q | sel;
      end
    end
  end

endmodule

// File: tb/tb_seg7_scan_decoder.sv
// tb/tb_seg7_scan_decoder.sv - directed and randomized checks of seg7_scan_decoder
module tb_seg7_scan_decoder;

  localparam int ND = 4;
  localparam int SC = 4;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [6:0]  seg = 7'h7f;
  logic [3:0]  an  = 4'hf;
  logic [15:0] value;
  logic [3:0]  digit_err;
  logic        frame_valid;
  logic [7:0]  glitch_cnt;

  int total = 0;
  int bad   = 0;
  int frames = 0;

  always #5 clk = ~clk;

  seg7_scan_decoder #(.NUM_DIGITS(ND), .STABLE_CYCLES(SC)) dut (
    .clk         (clk),
    .rst         (rst),
    .seg         (seg),
    .an          (an),
    .value       (value),
    .digit_err   (digit_err),
    .frame_valid (frame_valid),
    .glitch_cnt  (glitch_cnt)
  );

  logic [6:0] ref_glyph [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  // Reference model: a digit is accepted when a run of identical valid-select samples
  // reaches exactly SC; the frame publishes one cycle after all digits are collected.
  logic [10:0] m_smp, m_last;
  logic        m_last_ok;
  int          m_run;
  logic [3:0]  m_slot [4];
  logic        m_serr [4];
  logic [3:0]  m_mask;
  logic        m_pend;
  logic [15:0] m_value;
  logic [3:0]  m_err;
  logic        m_fv;
  int          m_glitch;

  function automatic int sel_index(input logic [3:0] a);
    int n = 0;
    int idx = -1;
    for (int i = 0; i < 4; i++) if (!a[i]) begin n++; idx = i; end
    return (n == 1) ? idx : -1;
  endfunction

  task automatic model_edge(input logic r, input logic [6:0] s, input logic [3:0] a);
    int d;
    int nib;
    logic err;
    if (!r) begin
      m_value = '0; m_err = '0; m_fv = 1'b0; m_glitch = 0;
      m_mask = '0; m_pend = 1'b0; m_run = 0; m_last_ok = 1'b0;
      m_last = '1; m_smp = '1;
      for (int i = 0; i < 4; i++) begin m_slot[i] = '0; m_serr[i] = 1'b0; end
    end else begin
      d = sel_index(m_smp[10:7]);
      m_fv = 1'b0;
      if (m_pend) begin
        m_value = {m_slot[3], m_slot[2], m_slot[1], m_slot[0]};
        m_err   = {m_serr[3], m_serr[2], m_serr[1], m_serr[0]};
        m_fv    = 1'b1;
        m_mask  = '0;
      end
      if (d < 0) begin
        m_glitch  = (m_glitch < 255) ? m_glitch + 1 : 255;
        m_run     = 0;
        m_last_ok = 1'b0;
      end else begin
        m_run     = (m_last_ok && m_smp == m_last) ? m_run + 1 : 1;
        m_last_ok = 1'b1;
        if (m_run == SC) begin
          nib = 0; err = 1'b1;
          for (int g = 0; g < 16; g++) if (m_smp[6:0] == ref_glyph[g]) begin nib = g; err = 1'b0; end
          m_slot[d] = 4'(nib);
          m_serr[d] = err;
          m_mask[d] = 1'b1;
        end
      end
      m_last = m_smp;
      m_pend = (m_mask == 4'hf);
      m_smp  = {a, s};
    end
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input logic [6:0] s, input logic [3:0] a);
    seg = s;
    an  = a;
    @(posedge clk);
    model_edge(rst, s, a);
    @(negedge clk);
    chk("frame_valid", 32'(frame_valid), 32'(m_fv));
    chk("value", 32'(value), 32'(m_value));
    chk("digit_err", 32'(digit_err), 32'(m_err));
    chk("glitch_cnt", 32'(glitch_cnt), 32'(m_glitch));
    if (frame_valid) frames++;
  endtask

  task automatic show(input int d, input logic [6:0] s, input int n);
    logic [3:0] one;
    one = 4'b0001;
    for (int k = 0; k < n; k++) tick(s, ~(one << d));
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) tick(7'h7f, 4'hf);
  endtask

  initial begin
    int d, len;
    logic [6:0] pat;
    logic [3:0] asel, one;
    one = 4'b0001;

    // reset state
    rst = 1'b0;
    idle(3);
    chk("rst_value", 32'(value), 32'h0);
    chk("rst_err", 32'(digit_err), 32'h0);
    chk("rst_fv", 32'(frame_valid), 32'h0);
    chk("rst_glitch", 32'(glitch_cnt), 32'h0);
    rst = 1'b1;

    // basic scan 1,2,3,4
    frames = 0;
    show(0, ref_glyph[1], 4); show(1, ref_glyph[2], 4);
    show(2, ref_glyph[3], 4); show(3, ref_glyph[4], 4);
    idle(3);
    chk("scan_frames", frames, 1);
    chk("scan_value", 32'(value), 32'h4321);
    chk("scan_err", 32'(digit_err), 32'h0);

    // digit 2 held one cycle short, then re-held
    frames = 0;
    show(0, ref_glyph[9], 4); show(1, ref_glyph[10], 4);
    show(2, ref_glyph[11], 3); show(3, ref_glyph[12], 4);
    idle(3);
    chk("short_frames", frames, 0);
    show(2, ref_glyph[11], 4);
    idle(3);
    chk("reheld_frames", frames, 1);
    chk("reheld_value", 32'(value), 32'hcba9);

    // blank digit decodes as illegal zero
    frames = 0;
    show(0, 7'b1111111, 4); show(1, ref_glyph[13], 4);
    show(2, ref_glyph[14], 4); show(3, ref_glyph[15], 4);
    idle(3);
    chk("blank_frames", frames, 1);
    chk("blank_err", 32'(digit_err), 32'h1);
    chk("blank_nib", 32'(value[3:0]), 32'h0);
    chk("blank_value", 32'(value), 32'hfed0);

    // two-digit glitch in the middle of a stable digit
    frames = 0;
    show(0, ref_glyph[0], 2);
    tick(ref_glyph[0], 4'b1100);
    show(0, ref_glyph[0], 4); show(1, ref_glyph[1], 4);
    show(2, ref_glyph[2], 4); show(3, ref_glyph[3], 4);
    idle(3);
    chk("glitch_frames", frames, 1);
    chk("glitch_value", 32'(value), 32'h3210);

    // reset discards a partial frame
    frames = 0;
    show(0, ref_glyph[5], 4); show(1, ref_glyph[6], 4); show(2, ref_glyph[7], 4);
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    show(0, ref_glyph[5], 4); show(1, ref_glyph[6], 4);
    show(2, ref_glyph[7], 4); show(3, ref_glyph[8], 4);
    idle(3);
    chk("rstmid_frames", frames, 1);
    chk("rstmid_value", 32'(value), 32'h8765);

    // randomized bursts against the model
    for (int b = 0; b < 150; b++) begin
      d   = $urandom_range(0, 3);
      len = $urandom_range(1, 7);
      pat = ($urandom_range(0, 9) == 0) ? 7'($urandom) : ref_glyph[$urandom_range(0, 15)];
      asel = ($urandom_range(0, 7) == 0) ? 4'($urandom) : ~(one << d);
      for (int k = 0; k < len; k++) tick(pat, asel);
    end

    // glitch counter saturation
    rst = 1'b0;
    idle(2);
    rst = 1'b1;
    idle(300);
    chk("glitch_sat", 32'(glitch_cnt), 32'd255);
    idle(5);
    chk("glitch_hold", 32'(glitch_cnt), 32'd255);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
